// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_arbiter                                            |
// | Description : Two-port req/ack arbiter for a single-port 32K x 8     |
// |               RAM. Port 0 = CPU, port 1 = loader/DMA. Bounded        |
// |               bursts, registered per-port read data.                 |
// | Option      : ARB_ROUND_ROBIN_EN - rotate tie priority between ports |
// |               (undefined: fixed priority, port 0 wins).              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ram_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    output logic [14:0] ram_address,
    output logic [7:0]  ram_datain,
    output logic        ram_we,
    input  logic [7:0]  ram_dataout
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

`ifdef ARB_ROUND_ROBIN_EN
    // Port 1 bursts follow the same lock/limit rules as port 0.
    localparam logic c_fixed_prio = 1'b0;
`else
    // Port 0 has absolute priority: any port 0 request ends a port 1 grant.
    localparam logic c_fixed_prio = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_burst_cnt;
    logic [7:0] w_burst_inc;
    logic       w_burst_done;
    logic       w_cut0;
    logic       w_cut1;

`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last;
`endif

    assign gnt0   = (r_state == ST_GNT0);
    assign gnt1   = (r_state == ST_GNT1);
    assign ack0   = gnt0 & req0;
    assign ack1   = gnt1 & req1;
    // Derived from the state register so an async reset drops it at once.
    assign ram_we = (ack0 & we0) | (ack1 & we1);

    // Count value after the ack happening this cycle; the limit is hit on
    // the ack that brings the count to MAX_BURST.
    assign w_burst_inc  = (r_burst_cnt == 8'hFF) ? 8'hFF : r_burst_cnt + 8'd1;
    assign w_burst_done = (w_burst_inc >= c_max_burst);

    // Grant is released after this ack when the other port is waiting.
    assign w_cut0 = req1 & (~lock0 | w_burst_done);
    assign w_cut1 = req0 & (~lock1 | w_burst_done | c_fixed_prio);

    // Steer the granted port onto the RAM; drive zeros when idle.
    always_comb begin
        ram_address = '0;
        ram_datain  = '0;
        case (r_state)
            ST_GNT0: begin
                ram_address = addr0;
                ram_datain  = wdata0;
            end
            ST_GNT1: begin
                ram_address = addr1;
                ram_datain  = wdata1;
            end
            default: ;
        endcase
    end

    // Next-state decision: tie resolution in IDLE, release rules in GNTx.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
`else
                    w_state_nxt = ST_GNT0;
`endif
                end else if (req0) begin
                    w_state_nxt = ST_GNT0;
                end else if (req1) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!req0 || w_cut0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!req1 || w_cut1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst counter: cleared while idle (i.e. on every grant entry), counts acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_burst_cnt <= 8'd0;
        end else if (ack0 || ack1) begin
            r_burst_cnt <= w_burst_inc;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember which port was granted last so the next tie goes the other way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_GNT0) begin
            r_last <= 1'b0;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_GNT1) begin
            r_last <= 1'b1;
        end
    end
`endif

    // Capture RAM read data for the port whose read is acked this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= 8'd0;
            rdata1 <= 8'd0;
        end else begin
            if (ack0 && !we0) begin
                rdata0 <= ram_dataout;
            end
            if (ack1 && !we1) begin
                rdata1 <= ram_dataout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ram_arbiter                                         |
// | Description : Directed self-checking bench for ram_arbiter with a    |
// |               behavioural 32K x 8 RAM (MAX_BURST = 4).               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ram_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [14:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1;
    logic [7:0]  rdata0, rdata1;
    logic [14:0] ram_address;
    logic [7:0]  ram_datain;
    logic        ram_we;
    logic [7:0]  ram_dataout;

    // RAM model: unwritten locations read as (low address byte + 0x10).
    bit [7:0] mem   [0:32767];
    bit       wflag [0:32767];

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .lock0       (lock0),
        .lock1       (lock1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .ram_address (ram_address),
        .ram_datain  (ram_datain),
        .ram_we      (ram_we),
        .ram_dataout (ram_dataout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_rd(input logic [14:0] a);
        return wflag[a] ? mem[a] : (a[7:0] + 8'h10);
    endfunction

    assign ram_dataout = model_rd(ram_address);

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_address]   <= ram_datain;
            wflag[ram_address] <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0011; wdata0 = 8'hAA; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 15'h0000; wdata1 = 8'h00; lock1 = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b expected 00", {gnt0, gnt1}); end
        total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL rst_ack: got %b expected 00", {ack0, ack1}); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b expected 0", ram_we); end
        total++; if ({rdata0, rdata1} !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h expected 0000", {rdata0, rdata1}); end
        total++; if (ram_address !== 15'h0000) begin bad++; $display("FAIL rst_addr: got %h expected 0000", ram_address); end
        step();
        @(negedge clk);
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL rst_req_ignored: got %b expected 0", gnt0); end
        req0 = 1'b0; we0 = 1'b0; addr0 = 15'h0000; wdata0 = 8'h00;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_simultaneous();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 15'h0001; addr1 = 15'h0002;
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL tie_first_idle: got %b expected 00", {gnt0, gnt1}); end
        step();
        @(negedge clk);
        total++; if ({gnt0, gnt1, ack0} !== 3'b101) begin bad++; $display("FAIL tie_first_gnt0: got %b expected 101", {gnt0, gnt1, ack0}); end
        total++; if (ram_address !== 15'h0001) begin bad++; $display("FAIL tie_first_addr: got %h expected 0001", ram_address); end
        step();
        addr0 = 15'h0003;
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL tie_gap_idle: got %b expected 00", {gnt0, gnt1}); end
        total++; if (rdata0 !== 8'h11) begin bad++; $display("FAIL tie_rdata0: got %h expected 11", rdata0); end
        step();
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== (c_rr ? 2'b01 : 2'b10)) begin bad++; $display("FAIL tie_second_winner: got %b expected %b", {gnt0, gnt1}, (c_rr ? 2'b01 : 2'b10)); end
        total++; if (ram_address !== (c_rr ? 15'h0002 : 15'h0003)) begin bad++; $display("FAIL tie_second_addr: got %h expected %h", ram_address, (c_rr ? 15'h0002 : 15'h0003)); end
        step();
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL tie_end_idle: got %b expected 00", {gnt0, gnt1}); end
        total++; if ({rdata0, rdata1} !== (c_rr ? 16'h1112 : 16'h1300)) begin bad++; $display("FAIL tie_rdata: got %h expected %h", {rdata0, rdata1}, (c_rr ? 16'h1112 : 16'h1300)); end
        step();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0020; wdata0 = 8'h5A; lock0 = 1'b0;
        @(negedge clk);
        total++; if ({gnt0, ram_we} !== 2'b00) begin bad++; $display("FAIL wr_latency: got %b expected 00", {gnt0, ram_we}); end
        step();
        @(negedge clk);
        total++; if ({gnt0, ack0, ram_we} !== 3'b111) begin bad++; $display("FAIL wr_ack: got %b expected 111", {gnt0, ack0, ram_we}); end
        total++; if ({ram_address, ram_datain} !== {15'h0020, 8'h5A}) begin bad++; $display("FAIL wr_bus: got %h expected %h", {ram_address, ram_datain}, {15'h0020, 8'h5A}); end
        step();
        we0 = 1'b0;
        @(negedge clk);
        total++; if ({ack0, ram_we} !== 2'b10) begin bad++; $display("FAIL rd_ack: got %b expected 10", {ack0, ram_we}); end
        total++; if (rdata0 !== (c_rr ? 8'h11 : 8'h13)) begin bad++; $display("FAIL rdata_held_over_write: got %h expected %h", rdata0, (c_rr ? 8'h11 : 8'h13)); end
        step();
        req0 = 1'b0;
        @(negedge clk);
        total++; if ({gnt0, ack0, ram_we} !== 3'b100) begin bad++; $display("FAIL rd_release: got %b expected 100", {gnt0, ack0, ram_we}); end
        total++; if (rdata0 !== 8'h5A) begin bad++; $display("FAIL rd_data: got %h expected 5a", rdata0); end
        step();
        @(negedge clk);
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL wr_rd_idle: got %b expected 0", gnt0); end
        step();
    endtask

    task automatic test_burst_limit();
        int  p1_next = 0;
        int  ack1_pre = 0;
        int  gap = 0;
        int  resume = -1;
        int  cyc = 0;
        bit  p0_done = 1'b0;
        bit  seen1 = 1'b0;
        while (cyc < 40 && !(p1_next == 10 && p0_done)) begin
            req1 = (p1_next < 10); addr1 = 15'(p1_next); lock1 = 1'b1; we1 = 1'b0;
            req0 = (cyc >= 1) && !p0_done; addr0 = 15'h0105; lock0 = 1'b0; we0 = 1'b0;
            @(negedge clk);
            total++; if (gnt0 && gnt1) begin bad++; $display("FAIL burst_mutex: got %b expected not 11", {gnt0, gnt1}); end
            if (ack1) begin
                total++; if (ram_address !== 15'(p1_next)) begin bad++; $display("FAIL burst_p1_addr: got %h expected %h", ram_address, 15'(p1_next)); end
                if (!p0_done) ack1_pre++;
                else if (resume < 0) resume = p1_next;
                seen1 = 1'b1;
                p1_next++;
            end
            if (ack0) begin
                total++; if (ram_address !== 15'h0105) begin bad++; $display("FAIL burst_p0_addr: got %h expected 0105", ram_address); end
                p0_done = 1'b1;
            end
            if (!gnt0 && !gnt1 && seen1 && !p0_done) gap++;
            step();
            cyc++;
        end
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        total++; if (p1_next != 10 || !p0_done) begin bad++; $display("FAIL burst_timeout: got p1=%0d p0=%0d expected p1=10 p0=1", p1_next, p0_done); end
        total++; if (ack1_pre != (c_rr ? 4 : 1)) begin bad++; $display("FAIL burst_len: got %0d expected %0d", ack1_pre, (c_rr ? 4 : 1)); end
        total++; if (gap != 1) begin bad++; $display("FAIL burst_switch_gap: got %0d expected 1", gap); end
        total++; if (resume != (c_rr ? 4 : 1)) begin bad++; $display("FAIL burst_resume_addr: got %0d expected %0d", resume, (c_rr ? 4 : 1)); end
        @(negedge clk);
        total++; if ({rdata0, rdata1} !== 16'h1519) begin bad++; $display("FAIL burst_rdata: got %h expected 1519", {rdata0, rdata1}); end
        step();
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL burst_end_idle: got %b expected 00", {gnt0, gnt1}); end
        step();
    endtask

    task automatic test_lone_burst();
        int next = 0;
        int idle_mid = 0;
        int cyc = 0;
        int prev_k = 0;
        bit prev_ack = 1'b0;
        while (cyc < 60 && next < 20) begin
            req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 15'h0040 + 15'(next);
            req1 = 1'b0;
            @(negedge clk);
            if (prev_ack) begin
                total++; if (rdata0 !== 8'h50 + 8'(prev_k)) begin bad++; $display("FAIL lone_rdata: got %h expected %h", rdata0, 8'h50 + 8'(prev_k)); end
            end
            if (ack0) begin
                total++; if (ram_address !== 15'h0040 + 15'(next)) begin bad++; $display("FAIL lone_addr: got %h expected %h", ram_address, 15'h0040 + 15'(next)); end
                prev_ack = 1'b1;
                prev_k = next;
                next++;
            end else begin
                prev_ack = 1'b0;
                if (next > 0) idle_mid++;
            end
            step();
            cyc++;
        end
        req0 = 1'b0; lock0 = 1'b0;
        total++; if (next != 20) begin bad++; $display("FAIL lone_count: got %0d expected 20", next); end
        total++; if (idle_mid != 0) begin bad++; $display("FAIL lone_gaps: got %0d expected 0", idle_mid); end
        @(negedge clk);
        total++; if (rdata0 !== 8'h63) begin bad++; $display("FAIL lone_last_rdata: got %h expected 63", rdata0); end
        step();
    endtask

    task automatic test_reset_mid_write();
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b0; addr1 = 15'h0022; wdata1 = 8'hFF;
        @(negedge clk);
        step();
        #1;
        total++; if ({gnt1, ram_we} !== 2'b11) begin bad++; $display("FAIL rstw_pre: got %b expected 11", {gnt1, ram_we}); end
        rst_n = 1'b0;
        #1;
        total++; if ({gnt1, ack1, ram_we} !== 3'b000) begin bad++; $display("FAIL rstw_drop: got %b expected 000", {gnt1, ack1, ram_we}); end
        step();
        @(negedge clk);
        total++; if (model_rd(15'h0022) !== 8'h32) begin bad++; $display("FAIL rstw_mem: got %h expected 32", model_rd(15'h0022)); end
        total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL rstw_hold: got %b expected 0", gnt1); end
        req1 = 1'b0; we1 = 1'b0; wdata1 = 8'h00;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        total++; if ({gnt0, gnt1, rdata0} !== {2'b00, 8'h00}) begin bad++; $display("FAIL rstw_after: got %h expected 000", {gnt0, gnt1, rdata0}); end
        step();
    endtask

    task automatic test_withdraw();
        req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 15'h0031;
        @(negedge clk);
        step();
        req1 = 1'b0;
        @(negedge clk);
        total++; if ({gnt1, ack1, ram_we} !== 3'b100) begin bad++; $display("FAIL wd_no_access: got %b expected 100", {gnt1, ack1, ram_we}); end
        step();
        @(negedge clk);
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL wd_idle: got %b expected 00", {gnt0, gnt1}); end
        total++; if (rdata1 !== 8'h00) begin bad++; $display("FAIL wd_rdata1: got %h expected 00", rdata1); end
        step();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_write_read();
        test_burst_limit();
        test_lone_burst();
        test_reset_mid_write();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
